// File: rtl/rob_pkg.sv
// rob_nway shared types: entry layout and index widths.
// Default geometry matches the rob_nway parameter defaults.
package rob_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int PRF_DEPTH = 64;
  localparam int PC_W      = 32;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int PRF_IDX_W = $clog2(PRF_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic                 mispredict;
    logic [PC_W-1:0]      pc;
    logic [PC_W-1:0]      target;
    logic [4:0]           dest;
    logic [PRF_IDX_W-1:0] tag;
    logic [PRF_IDX_W-1:0] tag_old;
    logic                 is_store;
  } ROB_NWAY_ENTRY;

endpackage

// File: rtl/rob_nway_retire_sel.sv
// rob_nway retire lane selection over the head window.
// Purely combinational; stops at the first blocked or mispredicted lane.
module rob_retire_sel
  import rob_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32,
  parameter int CW    = 6
) (
  input  ROB_NWAY_ENTRY              ent [WIDTH],
  input  logic                       retire_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           ret_mask,
  output logic [CW-1:0]              ret_cnt,
  output logic                       mp_hit,
  output logic [XLEN-1:0]            mp_tgt,
  output logic [WIDTH*5-1:0]         ret_dest,
  output logic [WIDTH*PRF_IDX_W-1:0] ret_tag,
  output logic [WIDTH*PRF_IDX_W-1:0] ret_tag_old,
  output logic [WIDTH-1:0]           ret_is_store
);

  logic go;
  logic st_seen;

  // walk lanes in order; any stop condition blocks all later lanes
  always_comb begin
    ret_mask = '0;
    ret_cnt  = '0;
    mp_hit   = 1'b0;
    mp_tgt   = '0;
    go       = retire_ready & ~flush;
    st_seen  = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (go && ent[k].valid && ent[k].done &&
          !(ent[k].is_store && st_seen)) begin
        ret_mask[k] = 1'b1;
        ret_cnt     = ret_cnt + CW'(1);
        st_seen     = st_seen | ent[k].is_store;
        if (ent[k].mispredict) begin
          mp_hit = 1'b1;
          mp_tgt = XLEN'(ent[k].target);
          go     = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  // retiring payload straight from the head window
  always_comb begin
    ret_dest     = '0;
    ret_tag      = '0;
    ret_tag_old  = '0;
    ret_is_store = '0;
    for (int k = 0; k < WIDTH; k++) begin
      ret_dest[k*5 +: 5]                = ent[k].dest;
      ret_tag[k*PRF_IDX_W +: PRF_IDX_W] = ent[k].tag;
      ret_tag_old[k*PRF_IDX_W +: PRF_IDX_W] = ent[k].tag_old;
      ret_is_store[k]                   = ent[k].is_store;
    end
  end

endmodule

// File: rtl/rob_nway.sv
// rob_nway: N-wide reorder buffer, slot-indexed completion,
// one store per retire cycle, flush on mispredicted retire.
module rob_nway
  import rob_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int ROB_SIZE  = ROB_DEPTH,
  parameter int CDB_WIDTH = 2,
  parameter int PRF_SIZE  = PRF_DEPTH,
  parameter int XLEN      = PC_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [WIDTH-1:0]                    dispatch_valid,
  input  logic [WIDTH*XLEN-1:0]               dispatch_pc,
  input  logic [WIDTH*5-1:0]                  dispatch_dest,
  input  logic [WIDTH*$clog2(PRF_SIZE)-1:0]   dispatch_tag,
  input  logic [WIDTH*$clog2(PRF_SIZE)-1:0]   dispatch_tag_old,
  input  logic [WIDTH-1:0]                    dispatch_is_store,
  output logic [WIDTH*$clog2(ROB_SIZE)-1:0]   dispatch_idx,
  output logic [$clog2(ROB_SIZE+1)-1:0]       free_slots,
  input  logic [CDB_WIDTH-1:0]                cmp_valid,
  input  logic [CDB_WIDTH*$clog2(ROB_SIZE)-1:0] cmp_idx,
  input  logic [CDB_WIDTH-1:0]                cmp_mispredict,
  input  logic [CDB_WIDTH*XLEN-1:0]           cmp_target,
  input  logic                                retire_ready,
  output logic [WIDTH-1:0]                    retire_valid,
  output logic [WIDTH*5-1:0]                  retire_dest,
  output logic [WIDTH*$clog2(PRF_SIZE)-1:0]   retire_tag,
  output logic [WIDTH*$clog2(PRF_SIZE)-1:0]   retire_tag_old,
  output logic [WIDTH-1:0]                    retire_is_store,
  output logic                                flush,
  output logic [XLEN-1:0]                     flush_pc
);

  localparam int IW = $clog2(ROB_SIZE);
  localparam int TW = $clog2(PRF_SIZE);
  localparam int CW = $clog2(ROB_SIZE+1);

  ROB_NWAY_ENTRY  rob_q [ROB_SIZE];
  ROB_NWAY_ENTRY  head_ent [WIDTH];
  logic [IW-1:0]  head_q;
  logic [IW-1:0]  tail_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  free_q;
  logic           flush_q;
  logic [XLEN-1:0] flush_pc_q;

  logic [WIDTH-1:0] ret_mask;
  logic [CW-1:0]    ret_cnt;
  logic             mp_hit;
  logic [XLEN-1:0]  mp_tgt;
  logic [WIDTH-1:0] acc_mask;
  logic [CW-1:0]    acc_cnt;
  logic [CW-1:0]    count_d;

  // head window seen by the retire selector
  always_comb begin
    for (int k = 0; k < WIDTH; k++)
      head_ent[k] = rob_q[head_q + IW'(k)];
  end

  rob_retire_sel #(
    .WIDTH (WIDTH),
    .XLEN  (XLEN),
    .CW    (CW)
  ) u_sel (
    .ent          (head_ent),
    .retire_ready (retire_ready),
    .flush        (flush_q),
    .ret_mask     (ret_mask),
    .ret_cnt      (ret_cnt),
    .mp_hit       (mp_hit),
    .mp_tgt       (mp_tgt),
    .ret_dest     (retire_dest),
    .ret_tag      (retire_tag),
    .ret_tag_old  (retire_tag_old),
    .ret_is_store (retire_is_store)
  );

  // lane acceptance against registered free space
  always_comb begin
    acc_mask = '0;
    acc_cnt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (dispatch_valid[i] && (CW'(i) < free_q) &&
          !flush_q && !mp_hit) begin
        acc_mask[i] = 1'b1;
        acc_cnt     = acc_cnt + CW'(1);
      end
    end
    count_d = count_q + acc_cnt - ret_cnt;
  end

  // slot offered to each dispatch lane
  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      dispatch_idx[i*IW +: IW] = tail_q + IW'(i);
  end

  assign retire_valid = ret_mask;
  assign free_slots   = free_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

  // pointers, occupancy, flush and entry array
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      free_q     <= CW'(ROB_SIZE);
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      for (int e = 0; e < ROB_SIZE; e++)
        rob_q[e] <= '0;
    end else begin
      flush_q <= mp_hit;
      if (mp_hit)
        flush_pc_q <= mp_tgt;
      if (mp_hit) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        free_q  <= CW'(ROB_SIZE);
        for (int e = 0; e < ROB_SIZE; e++) begin
          rob_q[e].valid      <= 1'b0;
          rob_q[e].done       <= 1'b0;
          rob_q[e].mispredict <= 1'b0;
        end
      end else begin
        head_q  <= head_q + IW'(ret_cnt);
        tail_q  <= tail_q + IW'(acc_cnt);
        count_q <= count_d;
        free_q  <= CW'(ROB_SIZE) - count_d;
        for (int k = 0; k < WIDTH; k++)
          if (ret_mask[k])
            rob_q[head_q + IW'(k)].valid <= 1'b0;
        if (!flush_q) begin
          for (int p = 0; p < CDB_WIDTH; p++) begin
            if (cmp_valid[p] && rob_q[cmp_idx[p*IW +: IW]].valid) begin
              rob_q[cmp_idx[p*IW +: IW]].done       <= 1'b1;
              rob_q[cmp_idx[p*IW +: IW]].mispredict <= cmp_mispredict[p];
              rob_q[cmp_idx[p*IW +: IW]].target     <=
                cmp_target[p*XLEN +: XLEN];
            end
          end
        end
        for (int i = 0; i < WIDTH; i++) begin
          if (acc_mask[i]) begin
            rob_q[tail_q + IW'(i)].valid      <= 1'b1;
            rob_q[tail_q + IW'(i)].done       <= 1'b0;
            rob_q[tail_q + IW'(i)].mispredict <= 1'b0;
            rob_q[tail_q + IW'(i)].pc         <= dispatch_pc[i*XLEN +: XLEN];
            rob_q[tail_q + IW'(i)].dest       <= dispatch_dest[i*5 +: 5];
            rob_q[tail_q + IW'(i)].tag        <= dispatch_tag[i*TW +: TW];
            rob_q[tail_q + IW'(i)].tag_old    <= dispatch_tag_old[i*TW +: TW];
            rob_q[tail_q + IW'(i)].is_store   <= dispatch_is_store[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_nway.sv
// rob_nway bench: queue-based reference model, directed
// scenarios with literal expectations, then random traffic.
module tb_rob_nway;

  localparam int W  = 2;
  localparam int RS = 32;
  localparam int CD = 2;
  localparam int XL = 32;
  localparam int IW = 5;
  localparam int TW = 6;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [W-1:0]    dispatch_valid;
  logic [W*XL-1:0] dispatch_pc;
  logic [W*5-1:0]  dispatch_dest;
  logic [W*TW-1:0] dispatch_tag;
  logic [W*TW-1:0] dispatch_tag_old;
  logic [W-1:0]    dispatch_is_store;
  logic [W*IW-1:0] dispatch_idx;
  logic [CW-1:0]   free_slots;
  logic [CD-1:0]   cmp_valid;
  logic [CD*IW-1:0] cmp_idx;
  logic [CD-1:0]   cmp_mispredict;
  logic [CD*XL-1:0] cmp_target;
  logic            retire_ready;
  logic [W-1:0]    retire_valid;
  logic [W*5-1:0]  retire_dest;
  logic [W*TW-1:0] retire_tag;
  logic [W*TW-1:0] retire_tag_old;
  logic [W-1:0]    retire_is_store;
  logic            flush;
  logic [XL-1:0]   flush_pc;

  always #5 clk = ~clk;

  rob_nway #(
    .WIDTH(W), .ROB_SIZE(RS), .CDB_WIDTH(CD), .PRF_SIZE(64), .XLEN(XL)
  ) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_pc(dispatch_pc),
    .dispatch_dest(dispatch_dest), .dispatch_tag(dispatch_tag),
    .dispatch_tag_old(dispatch_tag_old),
    .dispatch_is_store(dispatch_is_store),
    .dispatch_idx(dispatch_idx), .free_slots(free_slots),
    .cmp_valid(cmp_valid), .cmp_idx(cmp_idx),
    .cmp_mispredict(cmp_mispredict), .cmp_target(cmp_target),
    .retire_ready(retire_ready), .retire_valid(retire_valid),
    .retire_dest(retire_dest), .retire_tag(retire_tag),
    .retire_tag_old(retire_tag_old), .retire_is_store(retire_is_store),
    .flush(flush), .flush_pc(flush_pc)
  );

  typedef struct {
    int          slot;
    logic [4:0]  dest;
    logic [TW-1:0] tag;
    logic [TW-1:0] tag_old;
    bit          st;
    bit          done;
    bit          mp;
    logic [XL-1:0] tgt;
  } ment_t;

  ment_t q[$];
  int    m_tail;
  int    m_free;
  bit    m_flush;
  logic [XL-1:0] m_fpc;
  int    total = 0;
  int    bad = 0;

  logic [W-1:0]  e_mask;
  int            e_n;
  bit            e_hit;
  logic [XL-1:0] e_tgt;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail  = 0;
    m_free  = RS;
    m_flush = 0;
    m_fpc   = '0;
  endtask

  task automatic predict();
    bit seen;
    e_mask = '0;
    e_n    = 0;
    e_hit  = 0;
    e_tgt  = '0;
    seen   = 0;
    if (retire_ready && !m_flush) begin
      for (int k = 0; k < W; k++) begin
        if (k >= q.size()) break;
        if (!q[k].done) break;
        if (q[k].st && seen) break;
        e_mask[k] = 1'b1;
        e_n++;
        seen = seen | q[k].st;
        if (q[k].mp) begin
          e_hit = 1;
          e_tgt = q[k].tgt;
          break;
        end
      end
    end
  endtask

  task automatic compare();
    predict();
    chk("free_slots", 64'(free_slots), 64'(m_free));
    chk("flush", 64'(flush), 64'(m_flush));
    if (m_flush) chk("flush_pc", 64'(flush_pc), 64'(m_fpc));
    for (int i = 0; i < W; i++)
      chk("dispatch_idx", 64'(dispatch_idx[i*IW +: IW]),
          64'((m_tail + i) % RS));
    chk("retire_valid", 64'(retire_valid), 64'(e_mask));
    for (int k = 0; k < e_n; k++) begin
      chk("retire_dest", 64'(retire_dest[k*5 +: 5]), 64'(q[k].dest));
      chk("retire_tag", 64'(retire_tag[k*TW +: TW]), 64'(q[k].tag));
      chk("retire_tag_old", 64'(retire_tag_old[k*TW +: TW]),
          64'(q[k].tag_old));
      chk("retire_is_store", 64'(retire_is_store[k]), 64'(q[k].st));
    end
  endtask

  task automatic update();
    bit was_flush;
    int n;
    ment_t e;
    if (e_hit) begin
      q.delete();
      m_tail  = 0;
      m_free  = RS;
      m_flush = 1;
      m_fpc   = e_tgt;
      return;
    end
    was_flush = m_flush;
    m_flush   = 0;
    if (!was_flush)
      for (int p = 0; p < CD; p++)
        if (cmp_valid[p])
          foreach (q[j])
            if (q[j].slot == int'(cmp_idx[p*IW +: IW])) begin
              q[j].done = 1;
              q[j].mp   = cmp_mispredict[p];
              q[j].tgt  = cmp_target[p*XL +: XL];
            end
    repeat (e_n) void'(q.pop_front());
    n = 0;
    if (!was_flush)
      for (int i = 0; i < W; i++)
        if (dispatch_valid[i] && i < m_free) begin
          e.slot    = (m_tail + n) % RS;
          e.dest    = dispatch_dest[i*5 +: 5];
          e.tag     = dispatch_tag[i*TW +: TW];
          e.tag_old = dispatch_tag_old[i*TW +: TW];
          e.st      = dispatch_is_store[i];
          e.done    = 0;
          e.mp      = 0;
          e.tgt     = '0;
          q.push_back(e);
          n++;
        end
    m_tail = (m_tail + n) % RS;
    m_free = RS - q.size();
  endtask

  task automatic tick();
    compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic clr();
    dispatch_valid    = '0;
    dispatch_is_store = '0;
    cmp_valid         = '0;
    cmp_mispredict    = '0;
  endtask

  task automatic disp(int n, logic [W-1:0] st);
    for (int i = 0; i < W; i++) begin
      dispatch_valid[i]              = (i < n);
      dispatch_pc[i*XL +: XL]        = $urandom;
      dispatch_dest[i*5 +: 5]        = 5'($urandom);
      dispatch_tag[i*TW +: TW]       = TW'((m_tail + i) % RS);
      dispatch_tag_old[i*TW +: TW]   = TW'($urandom);
      dispatch_is_store[i]           = st[i];
    end
  endtask

  task automatic cmpl(int p, int idx, bit mp, logic [XL-1:0] t);
    cmp_valid[p]            = 1'b1;
    cmp_idx[p*IW +: IW]     = IW'(idx);
    cmp_mispredict[p]       = mp;
    cmp_target[p*XL +: XL]  = t;
  endtask

  task automatic drain();
    int p;
    for (int g = 0; g < 200 && q.size() > 0; g++) begin
      clr();
      retire_ready = 1'b1;
      p = 0;
      foreach (q[j])
        if (!q[j].done && p < CD) begin
          cmpl(p, q[j].slot, 0, '0);
          p++;
        end
      #1;
      tick();
    end
    #1;
    chk("drain_free", 64'(free_slots), 64'(RS));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int s0, s1;
    logic [W-1:0] stm;
    clr();
    dispatch_pc = '0; dispatch_dest = '0;
    dispatch_tag = '0; dispatch_tag_old = '0;
    cmp_idx = '0; cmp_target = '0;
    retire_ready = 1'b1;
    model_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_free", 64'(free_slots), 64'(32));
    chk("rst_rv", 64'(retire_valid), 64'(0));
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_fpc", 64'(flush_pc), 64'(0));
    reset = 1'b0;

    for (int c = 0; c < 3; c++) begin
      clr(); retire_ready = 1; disp(2, 2'b00); #1;
      chk("idx_l0", 64'(dispatch_idx[IW-1:0]), 64'(2*c));
      chk("idx_l1", 64'(dispatch_idx[2*IW-1:IW]), 64'(2*c+1));
      tick();
    end
    clr(); #1;
    chk("free_26", 64'(free_slots), 64'(26));
    chk("rv_idle", 64'(retire_valid), 64'(0));
    tick();

    clr(); retire_ready = 1; cmpl(0, 1, 0, '0); #1; tick();
    clr(); retire_ready = 1; cmpl(0, 0, 0, '0); #1;
    chk("rv_nobypass", 64'(retire_valid), 64'(0));
    tick();
    clr(); retire_ready = 1; #1;
    chk("rv_pair", 64'(retire_valid), 64'(2'b11));
    chk("rtag0", 64'(retire_tag[TW-1:0]), 64'(0));
    chk("rtag1", 64'(retire_tag[2*TW-1:TW]), 64'(1));
    tick();
    clr(); #1;
    chk("free_28", 64'(free_slots), 64'(28));
    tick();
    drain();

    for (int g = 0; g < 20 && m_tail != 30; g++) begin
      clr(); retire_ready = 0; disp(2, 2'b00); #1; tick();
    end
    drain();
    for (int c = 0; c < 16; c++) begin
      clr(); retire_ready = 0; disp(2, 2'b00); #1;
      if (c == 0) begin
        chk("wrap_l0", 64'(dispatch_idx[IW-1:0]), 64'(30));
        chk("wrap_l1", 64'(dispatch_idx[2*IW-1:IW]), 64'(31));
      end
      if (c == 1) chk("wrap_0", 64'(dispatch_idx[IW-1:0]), 64'(0));
      tick();
    end
    clr(); retire_ready = 0; disp(2, 2'b00); #1;
    chk("full_free", 64'(free_slots), 64'(0));
    tick();
    clr(); #1;
    chk("blocked_free", 64'(free_slots), 64'(0));
    chk("blocked_idx", 64'(dispatch_idx[IW-1:0]), 64'(30));
    tick();
    for (int c = 0; c < 16; c++) begin
      clr(); retire_ready = 0;
      cmpl(0, (30 + 2*c) % RS, 0, '0);
      cmpl(1, (31 + 2*c) % RS, 0, '0);
      #1; tick();
    end
    clr(); retire_ready = 1; #1;
    chk("wr_rv", 64'(retire_valid), 64'(2'b11));
    chk("wr_t30", 64'(retire_tag[TW-1:0]), 64'(30));
    chk("wr_t31", 64'(retire_tag[2*TW-1:TW]), 64'(31));
    tick();
    clr(); retire_ready = 1; #1;
    chk("wr_t0", 64'(retire_tag[TW-1:0]), 64'(0));
    chk("wr_t1", 64'(retire_tag[2*TW-1:TW]), 64'(1));
    chk("full_noreuse", 64'(free_slots), 64'(2));
    tick();
    drain();

    clr(); retire_ready = 0; disp(2, 2'b11); #1; tick();
    clr(); retire_ready = 0;
    cmpl(0, q[0].slot, 0, '0); cmpl(1, q[1].slot, 0, '0); #1; tick();
    clr(); retire_ready = 1; #1;
    chk("st_first", 64'(retire_valid), 64'(2'b01));
    tick();
    clr(); retire_ready = 1; #1;
    chk("st_second", 64'(retire_valid), 64'(2'b01));
    tick();
    drain();

    clr(); retire_ready = 0; disp(2, 2'b00); #1; tick();
    s0 = q[0].slot; s1 = q[1].slot;
    clr(); retire_ready = 0;
    cmpl(0, s0, 1, 32'h100); cmpl(1, s1, 0, '0); #1; tick();
    clr(); retire_ready = 1; #1;
    chk("mp_lane0", 64'(retire_valid), 64'(2'b01));
    tick();
    clr(); retire_ready = 1; disp(2, 2'b00); cmpl(0, 0, 0, '0); #1;
    chk("fl_flush", 64'(flush), 64'(1));
    chk("fl_pc", 64'(flush_pc), 64'(32'h100));
    chk("fl_free", 64'(free_slots), 64'(32));
    chk("fl_rv", 64'(retire_valid), 64'(0));
    tick();
    clr(); #1;
    chk("fl_ign_free", 64'(free_slots), 64'(32));
    chk("fl_ign_idx", 64'(dispatch_idx[IW-1:0]), 64'(0));
    tick();

    clr(); retire_ready = 0; disp(2, 2'b00); #1; tick();
    clr(); retire_ready = 0;
    cmpl(0, q[0].slot, 1, 32'h2468); cmpl(1, q[1].slot, 0, '0); #1; tick();
    clr(); retire_ready = 1; #1; tick();
    chk("pre_rst_flush", 64'(flush), 64'(1));
    reset = 1'b1; #1;
    chk("rst_fl_flush", 64'(flush), 64'(0));
    chk("rst_fl_free", 64'(free_slots), 64'(32));
    chk("rst_fl_pc", 64'(flush_pc), 64'(0));
    model_reset();
    @(negedge clk); reset = 1'b0;

    clr(); retire_ready = 0; disp(2, 2'b00); #1; tick();
    clr(); retire_ready = 0;
    cmpl(0, q[0].slot, 0, '0); cmpl(1, q[1].slot, 0, '0); #1; tick();
    clr(); retire_ready = 0; #1; tick();
    retire_ready = 1; reset = 1'b1; #1;
    chk("rst_st_rv", 64'(retire_valid), 64'(0));
    chk("rst_st_free", 64'(free_slots), 64'(32));
    model_reset();
    @(negedge clk); reset = 1'b0;
    clr(); retire_ready = 1; disp(2, 2'b00); #1;
    chk("post_rst_idx", 64'(dispatch_idx[IW-1:0]), 64'(0));
    tick();

    for (int c = 0; c < 3000; c++) begin
      clr();
      retire_ready = ($urandom % 4) != 0;
      nd = $urandom_range(0, W);
      if (nd > m_free) nd = m_free;
      stm = W'($urandom);
      disp(nd, stm);
      for (int p = 0; p < CD; p++) begin
        if (($urandom % 2) == 1 && q.size() > 0) begin
          s0 = $urandom_range(0, q.size() - 1);
          cmpl(p, q[s0].slot, ($urandom % 16) == 0, $urandom);
        end else if (($urandom % 8) == 0) begin
          cmpl(p, $urandom % RS, ($urandom % 16) == 0, $urandom);
        end
      end
      #1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
